// File: rtl/axi_lite_stream_master.sv
// ---------------------------------------------------------------------------
// axi_lite_stream_master
//
// Converts a command stream into single AXI4-Lite transactions. Each command
// carries an address (upper ADDR_WD bits of s_tdata) and data (lower DATA_WD
// bits). The keep bits select the operation:
//   address keep all ones, data keep non-zero -> write, wstrb = data keep
//   address keep all ones, data keep zero     -> read, result on rd_* stream
//   address keep not all ones                 -> dropped, counted as error
// Only one transaction is in flight at a time.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   s_tvalid/s_tready/s_tdata/s_tkeep   command stream in
//   aw*, w*, b*                   AXI-lite write channels
//   ar*, r*                       AXI-lite read channels
//   rd_tvalid/rd_tready/rd_tdata/rd_tresp  read result stream out
//   err_cnt                       saturating count of error responses and
//                                 dropped commands
// ---------------------------------------------------------------------------
module axi_lite_stream_master #(
   parameter int DATA_WD = 32,
   parameter int ADDR_WD = 32,
   parameter int CNT_WD  = 16,
   localparam int KEEP_WD = (ADDR_WD + DATA_WD) / 8,
   localparam int STRB_WD = DATA_WD / 8
) (
   input  logic                       clk,
   input  logic                       rst,
   // command stream
   input  logic                       s_tvalid,
   output logic                       s_tready,
   input  logic [ADDR_WD+DATA_WD-1:0] s_tdata,
   input  logic [KEEP_WD-1:0]         s_tkeep,
   // write address / data / response
   output logic                       awvalid,
   input  logic                       awready,
   output logic [ADDR_WD-1:0]         awaddr,
   output logic                       wvalid,
   input  logic                       wready,
   output logic [DATA_WD-1:0]         wdata,
   output logic [STRB_WD-1:0]         wstrb,
   input  logic                       bvalid,
   output logic                       bready,
   input  logic [1:0]                 bresp,
   // read address / data
   output logic                       arvalid,
   input  logic                       arready,
   output logic [ADDR_WD-1:0]         araddr,
   input  logic                       rvalid,
   output logic                       rready,
   input  logic [DATA_WD-1:0]         rdata,
   input  logic [1:0]                 rresp,
   // read result stream
   output logic                       rd_tvalid,
   input  logic                       rd_tready,
   output logic [DATA_WD-1:0]         rd_tdata,
   output logic [1:0]                 rd_tresp,
   // status
   output logic [CNT_WD-1:0]          err_cnt
);

   localparam int AKEEP_WD = ADDR_WD / 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR   = 3'd1,
      WB   = 3'd2,
      RA   = 3'd3,
      RD   = 3'd4,
      RO   = 3'd5
   } state_t;

   state_t              state_reg, state_next;
   logic [ADDR_WD-1:0]  addr_reg;
   logic [DATA_WD-1:0]  data_reg;
   logic [STRB_WD-1:0]  strb_reg;
   logic                aw_pend_reg;
   logic                w_pend_reg;
   logic [DATA_WD-1:0]  rd_data_reg;
   logic [1:0]          rd_resp_reg;
   logic [CNT_WD-1:0]   err_cnt_reg;

   logic                addr_keep_full;
   logic [STRB_WD-1:0]  data_keep;
   logic                accept;
   logic                is_write;
   logic                err_inc;

   assign addr_keep_full = &s_tkeep[KEEP_WD-1 -: AKEEP_WD];
   assign data_keep      = s_tkeep[STRB_WD-1:0];
   assign accept         = s_tvalid && (state_reg == IDLE);
   assign is_write       = addr_keep_full && (data_keep != '0);

   // Next state, handshake outputs and error increment. Valids come from
   // registered state only, so no valid ever waits on a ready combinationally.
   always_comb begin
      state_next = state_reg;
      err_inc    = 1'b0;
      s_tready   = 1'b0;
      awvalid    = 1'b0;
      wvalid     = 1'b0;
      bready     = 1'b0;
      arvalid    = 1'b0;
      rready     = 1'b0;
      rd_tvalid  = 1'b0;
      case (state_reg)
         IDLE: begin
            s_tready = 1'b1;
            if (s_tvalid) begin
               if (!addr_keep_full) begin
                  err_inc = 1'b1;
               end else if (data_keep != '0) begin
                  state_next = WR;
               end else begin
                  state_next = RA;
               end
            end
         end
         WR: begin
            awvalid = aw_pend_reg;
            wvalid  = w_pend_reg;
            // Each channel counts as done if it already fired or fires now.
            if ((!aw_pend_reg || awready) && (!w_pend_reg || wready)) begin
               state_next = WB;
            end
         end
         WB: begin
            bready = 1'b1;
            if (bvalid) begin
               state_next = IDLE;
               err_inc    = (bresp != 2'b00);
            end
         end
         RA: begin
            arvalid = 1'b1;
            if (arready) begin
               state_next = RD;
            end
         end
         RD: begin
            rready = 1'b1;
            if (rvalid) begin
               state_next = RO;
               err_inc    = (rresp != 2'b00);
            end
         end
         RO: begin
            rd_tvalid = 1'b1;
            if (rd_tready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         addr_reg    <= '0;
         data_reg    <= '0;
         strb_reg    <= '0;
         aw_pend_reg <= 1'b0;
         w_pend_reg  <= 1'b0;
         rd_data_reg <= '0;
         rd_resp_reg <= 2'b00;
         err_cnt_reg <= '0;
      end else begin
         state_reg <= state_next;

         if (accept) begin
            addr_reg    <= s_tdata[ADDR_WD+DATA_WD-1 -: ADDR_WD];
            data_reg    <= s_tdata[DATA_WD-1:0];
            strb_reg    <= data_keep;
            aw_pend_reg <= is_write;
            w_pend_reg  <= is_write;
         end

         if (state_reg == WR) begin
            if (awready) begin
               aw_pend_reg <= 1'b0;
            end
            if (wready) begin
               w_pend_reg <= 1'b0;
            end
         end

         if ((state_reg == RD) && rvalid) begin
            rd_data_reg <= rdata;
            rd_resp_reg <= rresp;
         end

         // Saturate rather than wrap so a stuck error source stays visible.
         if (err_inc && (err_cnt_reg != {CNT_WD{1'b1}})) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
         end
      end
   end

   assign awaddr   = addr_reg;
   assign araddr   = addr_reg;
   assign wdata    = data_reg;
   assign wstrb    = strb_reg;
   assign rd_tdata = rd_data_reg;
   assign rd_tresp = rd_resp_reg;
   assign err_cnt  = err_cnt_reg;

endmodule

// File: tb/tb_axi_lite_stream_master.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_stream_master
//
// Directed bench for axi_lite_stream_master with 8-bit address and data and
// a 4-bit error counter. A transaction-level model (queues of expected AXI
// beats and result words, a busy flag and an error count) is checked against
// the DUT on every falling edge; directed steps add literal expectations.
// ---------------------------------------------------------------------------
module tb_axi_lite_stream_master;

   localparam int DW = 8;
   localparam int AW = 8;
   localparam int CW = 4;
   localparam int KW = (AW + DW) / 8;
   localparam int SW = DW / 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_tvalid;
   logic          s_tready;
   logic [AW+DW-1:0] s_tdata;
   logic [KW-1:0] s_tkeep;
   logic          awvalid, awready;
   logic [AW-1:0] awaddr;
   logic          wvalid, wready;
   logic [DW-1:0] wdata;
   logic [SW-1:0] wstrb;
   logic          bvalid, bready;
   logic [1:0]    bresp;
   logic          arvalid, arready;
   logic [AW-1:0] araddr;
   logic          rvalid, rready;
   logic [DW-1:0] rdata;
   logic [1:0]    rresp;
   logic          rd_tvalid, rd_tready;
   logic [DW-1:0] rd_tdata;
   logic [1:0]    rd_tresp;
   logic [CW-1:0] err_cnt;

   // slave-side drivers: 0 awready, 1 wready, 2 bvalid, 3 arready, 4 rvalid, 5 rd_tready
   logic [5:0] drv = '0;
   int         dly [6];

   assign awready   = drv[0];
   assign wready    = drv[1];
   assign bvalid    = drv[2];
   assign arready   = drv[3];
   assign rvalid    = drv[4];
   assign rd_tready = drv[5];

   always #5 clk = ~clk;

   axi_lite_stream_master #(.DATA_WD(DW), .ADDR_WD(AW), .CNT_WD(CW)) dut (
      .clk(clk), .rst(rst),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .rd_tvalid(rd_tvalid), .rd_tready(rd_tready), .rd_tdata(rd_tdata), .rd_tresp(rd_tresp),
      .err_cnt(err_cnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- slave responders ----------------
   // Each channel raises its driver after dly[i] cycles of seeing the
   // opposite side asserted, and drops it after the handshake.
   initial begin
      logic [5:0] v, h;
      int wt [6];
      for (int i = 0; i < 6; i++) wt[i] = 0;
      forever begin
         @(negedge clk);
         v = {rd_tvalid, rready, arvalid, bready, wvalid, awvalid};
         h = v & drv;
         @(posedge clk);
         #1;
         for (int i = 0; i < 6; i++) begin
            if (h[i] || !v[i]) begin
               drv[i] = 1'b0;
               wt[i]  = 0;
            end else if (wt[i] >= dly[i]) begin
               drv[i] = 1'b1;
            end else begin
               wt[i]++;
            end
         end
      end
   end

   // ---------------- transaction model + per-cycle compare ----------------
   logic [AW-1:0]   q_aw [$];
   logic [DW+SW-1:0] q_w [$];
   logic [AW-1:0]   q_ar [$];
   logic [DW+1:0]   q_rd [$];
   logic            busy = 1'b0;
   logic [CW-1:0]   exp_err = '0;
   int              cyc = 0;
   int              b_cnt = 0, aw_t = 0, w_t = 0, rd_v_cyc = 0, last_rd_cyc = 0;
   logic [AW-1:0]   last_awaddr, last_araddr;
   logic [DW-1:0]   last_wdata, last_rd_tdata;
   logic [SW-1:0]   last_wstrb;
   logic [1:0]      last_rd_tresp;
   logic            p_aw = 0, p_w = 0, p_ar = 0, p_rd = 0;
   logic [AW-1:0]   p_awaddr, p_araddr;
   logic [DW+SW-1:0] p_w_pl;
   logic [DW+1:0]   p_rd_pl;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
      return (x == {CW{1'b1}}) ? x : x + 1'b1;
   endfunction

   always @(negedge clk) begin
      logic [KW-AW/8-1+AW/8:0] k;
      cyc++;
      if (rst) begin
         q_aw.delete(); q_w.delete(); q_ar.delete(); q_rd.delete();
         busy = 1'b0; exp_err = '0; rd_v_cyc = 0;
         p_aw = 0; p_w = 0; p_ar = 0; p_rd = 0;
      end else begin
         check("err_cnt", err_cnt, exp_err);
         check("s_tready", s_tready, !busy);
         // valids must hold with stable payload until handshake
         if (p_aw) check("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
         if (p_w)  check("w_hold",  {wvalid, wdata, wstrb}, {1'b1, p_w_pl});
         if (p_ar) check("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
         if (p_rd) check("rd_hold", {rd_tvalid, rd_tdata, rd_tresp}, {1'b1, p_rd_pl});
         // response channels only once the request side is fully done
         if (bready) check("b_phase", busy && q_aw.size() == 0 && q_w.size() == 0, 1);
         if (rready) check("r_phase", busy && q_ar.size() == 0, 1);
         if (awvalid) check("aw_expected", q_aw.size() != 0, 1);
         if (wvalid)  check("w_expected",  q_w.size() != 0, 1);
         if (arvalid) check("ar_expected", q_ar.size() != 0, 1);
         if (rd_tvalid) begin
            check("rd_expected", q_rd.size() != 0, 1);
            rd_v_cyc++;
         end

         if (awvalid && awready && q_aw.size() != 0) begin
            check("awaddr", awaddr, q_aw.pop_front());
            last_awaddr = awaddr; aw_t = cyc;
         end
         if (wvalid && wready && q_w.size() != 0) begin
            check("wdata_wstrb", {wdata, wstrb}, q_w.pop_front());
            last_wdata = wdata; last_wstrb = wstrb; w_t = cyc;
         end
         if (arvalid && arready && q_ar.size() != 0) begin
            check("araddr", araddr, q_ar.pop_front());
            last_araddr = araddr;
         end
         if (bvalid && bready) begin
            b_cnt++;
            if (bresp != 2'b00) exp_err = sat_inc(exp_err);
            busy = 1'b0;
         end
         if (rvalid && rready) begin
            q_rd.push_back({rdata, rresp});
            if (rresp != 2'b00) exp_err = sat_inc(exp_err);
         end
         if (rd_tvalid && rd_tready && q_rd.size() != 0) begin
            check("rd_result", {rd_tdata, rd_tresp}, q_rd.pop_front());
            last_rd_tdata = rd_tdata; last_rd_tresp = rd_tresp;
            last_rd_cyc = rd_v_cyc; rd_v_cyc = 0;
            busy = 1'b0;
         end
         if (s_tvalid && s_tready) begin
            k = s_tkeep;
            if (&k[KW-1 -: AW/8]) begin
               busy = 1'b1;
               if (k[SW-1:0] != '0) begin
                  q_aw.push_back(s_tdata[AW+DW-1 -: AW]);
                  q_w.push_back({s_tdata[DW-1:0], k[SW-1:0]});
               end else begin
                  q_ar.push_back(s_tdata[AW+DW-1 -: AW]);
               end
            end else begin
               exp_err = sat_inc(exp_err);
            end
         end

         p_aw = awvalid && !awready;      p_awaddr = awaddr;
         p_w  = wvalid && !wready;        p_w_pl   = {wdata, wstrb};
         p_ar = arvalid && !arready;      p_araddr = araddr;
         p_rd = rd_tvalid && !rd_tready;  p_rd_pl  = {rd_tdata, rd_tresp};
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic send_cmd(input logic [AW+DW-1:0] d, input logic [KW-1:0] k);
      logic ok = 1'b0;
      s_tdata  = d;
      s_tkeep  = k;
      s_tvalid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (s_tready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      s_tvalid = 1'b0;
      check("cmd_accept_timeout", ok, 1);
   endtask

   task automatic wait_idle();
      logic ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (s_tready) ok = 1'b1;
      end
      check("idle_timeout", ok, 1);
   endtask

   initial begin
      int b0;
      logic seen;
      for (int i = 0; i < 6; i++) dly[i] = 0;
      rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0;
      bresp = 2'b00; rdata = '0; rresp = 2'b00;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      @(negedge clk);
      check("rst_s_tready", s_tready, 1);
      check("rst_valids", {awvalid, wvalid, arvalid, rd_tvalid, bready, rready}, 0);
      check("rst_err_cnt", err_cnt, 0);
      @(posedge clk); #1;

      // plain write
      send_cmd(16'h5A5A, 2'b11);
      @(negedge clk);
      check("wr_latency", {awvalid, wvalid}, 2'b11);
      wait_idle();
      check("wr_awaddr", last_awaddr, 8'h5A);
      check("wr_wdata", last_wdata, 8'h5A);
      check("wr_wstrb", last_wstrb, 1'b1);
      check("wr_b_count", b_cnt, 1);
      check("wr_err_cnt", err_cnt, 0);
      @(posedge clk); #1;

      // plain read
      rdata = 8'hC3; rresp = 2'b00;
      send_cmd({8'h10, 8'h00}, 2'b10);
      @(negedge clk);
      check("rd_latency", arvalid, 1);
      wait_idle();
      check("rd_araddr", last_araddr, 8'h10);
      check("rd_tdata", last_rd_tdata, 8'hC3);
      check("rd_tresp", last_rd_tresp, 2'b00);
      @(posedge clk); #1;

      // awready three cycles ahead of wready
      dly[1] = 3; b0 = b_cnt;
      send_cmd({8'h33, 8'hA7}, 2'b11);
      wait_idle();
      check("split_w_after_aw", w_t - aw_t, 3);
      check("split_b_count", b_cnt - b0, 1);
      check("split_wdata", last_wdata, 8'hA7);
      dly[1] = 0;
      @(posedge clk); #1;

      // dropped command, then write with SLVERR
      send_cmd({8'h44, 8'h55}, 2'b01);
      wait_idle();
      check("drop_err_cnt", err_cnt, 1);
      check("drop_no_bus", {awvalid, arvalid}, 0);
      @(posedge clk); #1;
      bresp = 2'b10;
      send_cmd({8'h20, 8'h01}, 2'b11);
      wait_idle();
      check("bresp_err_cnt", err_cnt, 2);
      bresp = 2'b00;
      @(posedge clk); #1;

      // read with error response
      rdata = 8'h99; rresp = 2'b11;
      send_cmd({8'h77, 8'h00}, 2'b10);
      wait_idle();
      check("rresp_err_cnt", err_cnt, 3);
      check("rresp_tresp", last_rd_tresp, 2'b11);
      check("rresp_tdata", last_rd_tdata, 8'h99);
      rresp = 2'b00;
      @(posedge clk); #1;

      // result stream back-pressured for five cycles
      dly[5] = 4; rdata = 8'h6E;
      send_cmd({8'h81, 8'h00}, 2'b10);
      wait_idle();
      check("bp_valid_cycles", last_rd_cyc, 6);
      check("bp_rd_tdata", last_rd_tdata, 8'h6E);
      dly[5] = 0;
      @(posedge clk); #1;

      // reset while waiting for the write response
      dly[2] = 60;
      send_cmd({8'hE0, 8'h0F}, 2'b11);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (bready) seen = 1'b1;
      end
      check("wb_reached", seen, 1);
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("wb_rst_valids", {awvalid, wvalid, arvalid, rd_tvalid, bready, rready}, 0);
      check("wb_rst_s_tready", s_tready, 1);
      check("wb_rst_err_cnt", err_cnt, 0);
      dly[2] = 0;
      @(posedge clk); #1;

      // counter saturation: 16 drops, then one more error response
      for (int i = 0; i < 16; i++) begin
         send_cmd({8'(i), 8'(i * 3)}, (i % 2 == 0) ? 2'b00 : 2'b01);
      end
      wait_idle();
      check("sat_err_cnt", err_cnt, 15);
      @(posedge clk); #1;
      bresp = 2'b01;
      send_cmd({8'h3C, 8'hC3}, 2'b11);
      wait_idle();
      check("sat_hold", err_cnt, 15);
      bresp = 2'b00;

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
